// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: six one-entry holding slots, round-robin granted onto
// NPORT registered writeback/wakeup broadcast ports.
module wb_port_arbiter #(
    parameter int NREQ   = 6,
    parameter int NPORT  = 2,
    parameter int TAG_W  = 6,
    parameter int WIN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*TAG_W-1:0]     req_tag,
    input  logic [NREQ*WIN_W-1:0]     req_win,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NPORT-1:0]          wb_valid,
    output logic [NPORT*TAG_W-1:0]    wb_tag,
    output logic [NPORT*WIN_W-1:0]    wb_win,
    output logic [NPORT*DATA_W-1:0]   wb_data,
    output logic [NPORT*3-1:0]        wb_src
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDX_W = PTR_W + 1;
    localparam int CNT_W = $clog2(NPORT + 1);

    logic [NREQ-1:0]   r_full;
    logic [TAG_W-1:0]  r_tag  [NREQ];
    logic [WIN_W-1:0]  r_win  [NREQ];
    logic [DATA_W-1:0] r_data [NREQ];
    logic [PTR_W-1:0]  r_rr_ptr;

    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_accept;
    logic              w_any;
    logic [PTR_W-1:0]  w_last;
    logic [PTR_W-1:0]  w_rr_next;
    logic [NPORT-1:0]  w_port_vld;
    logic [PTR_W-1:0]  w_port_sel [NPORT];

    // Grant is a function of registered state only, so ready never depends on req_valid.
    always_comb begin : grant_scan
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
        w_grant    = '0;
        w_port_vld = '0;
        w_any      = 1'b0;
        w_last     = '0;
        idx        = '0;
        cnt        = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_port_sel[p] = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, r_rr_ptr} + IDX_W'(k);
            if (idx >= IDX_W'(NREQ)) begin
                idx = idx - IDX_W'(NREQ);
            end
            if (r_full[idx[PTR_W-1:0]] && (cnt < CNT_W'(NPORT))) begin
                w_grant[idx[PTR_W-1:0]] = 1'b1;
                for (int p = 0; p < NPORT; p++) begin
                    if (cnt == CNT_W'(p)) begin
                        w_port_vld[p] = 1'b1;
                        w_port_sel[p] = idx[PTR_W-1:0];
                    end
                end
                cnt    = cnt + CNT_W'(1);
                w_any  = 1'b1;
                w_last = idx[PTR_W-1:0];
            end
        end
    end

    assign w_rr_next = (w_last == PTR_W'(NREQ - 1)) ? '0 : w_last + PTR_W'(1);
    assign req_ready = ~r_full | w_grant;
    assign w_accept  = req_valid & req_ready & {NREQ{~flush}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= '0;
            r_rr_ptr <= '0;
            wb_valid <= '0;
            wb_tag   <= '0;
            wb_win   <= '0;
            wb_data  <= '0;
            wb_src   <= '0;
        end else if (flush) begin
            r_full   <= '0;
            wb_valid <= '0;
            wb_tag   <= '0;
            wb_win   <= '0;
            wb_data  <= '0;
            wb_src   <= '0;
        end else begin
            // A same-cycle refill keeps the slot full; the granted result still leaves.
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept[i]) begin
                    r_full[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_any) begin
                r_rr_ptr <= w_rr_next;
            end
            for (int p = 0; p < NPORT; p++) begin
                wb_valid[p]                  <= w_port_vld[p];
                wb_tag[p*TAG_W +: TAG_W]     <= w_port_vld[p] ? r_tag[w_port_sel[p]]  : '0;
                wb_win[p*WIN_W +: WIN_W]     <= w_port_vld[p] ? r_win[w_port_sel[p]]  : '0;
                wb_data[p*DATA_W +: DATA_W]  <= w_port_vld[p] ? r_data[w_port_sel[p]] : '0;
                wb_src[p*3 +: 3]             <= w_port_vld[p] ? 3'(w_port_sel[p])     : 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_accept[i]) begin
                r_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                r_win[i]  <= req_win[i*WIN_W +: WIN_W];
                r_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback-port arbiter between the execution units (ALU0–ALU3, BU, DU) and the shared writeback/wakeup broadcast ports that feed the issue window and the commit bookkeeping. Each unit hands over a result (physical destination tag, commit-window index, data) through a valid/ready handshake into a private one-entry holding slot. Every cycle a round-robin scheduler grants up to NPORT occupied slots to the registered writeback ports. This bounds broadcast fan-in regardless of how many units finish in the same cycle.

## Interface
- NREQ, 6, number of requesters (index 0–3 ALU0–3, 4 BU, 5 DU)
- NPORT, 2, writeback ports; 1 ≤ NPORT ≤ NREQ
- TAG_W, 6, physical register tag width
- WIN_W, 4, commit-window index width
- DATA_W, 32, result width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush, synchronous
- req_valid  in  NREQ  requester i has a result
- req_ready  out  NREQ  slot i can accept this cycle
- req_tag  in  NREQ*TAG_W  requester i tag at [i*TAG_W +: TAG_W]
- req_win  in  NREQ*WIN_W  commit-window index, same packing
- req_data  in  NREQ*DATA_W  result data, same packing
- wb_valid  out  NPORT  port p carries a result this cycle
- wb_tag  out  NPORT*TAG_W  port p tag, packed as above
- wb_win  out  NPORT*WIN_W  port p window index
- wb_data  out  NPORT*DATA_W  port p data
- wb_src  out  NPORT*3  requester index driving port p

## Operation
- State:
  - per-requester slot: full bit + tag/win/data
  - rr_ptr, range 0..NREQ-1
  - registered port outputs
- Accept: slot i loads when req_valid[i] & req_ready[i] & !flush.
- Ready: req_ready[i] = !full[i] | grant[i]. Grant depends only on registered state, so there is no combinational path from req_valid to req_ready.
- Grant: scan full slots in circular order rr_ptr, rr_ptr+1, …, wrapping mod NREQ.
  - First NPORT full slots found are granted.
  - First found drives port 0, second drives port 1, etc.
- Granted slot clears at next edge, unless refilled by a same-cycle accept, in which case it stays full with the new contents.
- rr_ptr:
  - Becomes (index of last granted slot + 1) mod NREQ.
  - Unchanged when nothing is granted.
- Ports with no grant: wb_valid=0 and wb_tag/wb_win/wb_data/wb_src all zero.
- Flush:
  - Clears all full bits and all wb_* registers at the edge.
  - Input accepts in the flush cycle are dropped.
  - rr_ptr is retained.
- Reset: as flush, plus rr_ptr=0.

## Timing
- Reset values:
  - wb_valid, wb_tag, wb_win, wb_data, wb_src = 0
  - all slots empty, rr_ptr=0
  - req_ready = all ones from the first cycle after reset
- Latency: accept at edge t, slot full during cycle t+1. If granted in t+1, wb_* are valid during cycle t+2. Minimum latency is 2 cycles.
- Throughput: each requester can sustain one result per cycle while granted every cycle.
- Occupancy: a full, ungranted slot holds req_ready[i]=0. Data is held unchanged until granted.
- Starvation bound: a full slot is granted within ceil(NREQ/NPORT) cycles, i.e. 3 for the defaults.
- Simultaneous events:
  - rst has priority over flush.
  - flush has priority over grant and accept.
  - When grant and accept hit the same slot, the accept wins the slot and the granted result still goes out.
- wb_* are registered outputs, valid for exactly one cycle per grant. There is no back-pressure from the ports.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → after release, wb_valid=00, all wb fields 0, req_ready=6'b111111.
- Single result: req_valid[4]=1 for one cycle with tag=6'h2A, win=4'h7, data=32'hDEADBEEF at cycle t → in cycle t+2, wb_valid=01, wb_tag[0]=2A, wb_win[0]=7, wb_data[0]=DEADBEEF, wb_src[0]=4; port 1 all zero.
- Burst: all 6 requesters valid for one cycle, rr_ptr=0 → grants (0,1), then (2,3), then (4,5) on consecutive cycles. rr_ptr returns to 0. req_ready[5] stays low until its grant cycle.
- Fairness: requesters 0, 1, 2 continuously valid → port pairs rotate (0,1), (2,0), (1,2), (0,1). No requester waits more than 2 cycles.
- Flush: slots 1, 3, 5 full and requester 0 presenting valid in the flush cycle → next cycle wb_valid=00, all ready high, req 0 dropped, rr_ptr unchanged.
- Same-slot grant + refill: slot 2 granted while req_valid[2]=1 with new data → old data appears on the port next cycle, new data is granted on a later cycle. No loss and no duplication, checked by a scoreboard over 10k random cycles.
